lcd_controller: RTL and testbench
=================================

Name: lcd_controller

Overview:
- Drives an HD44780-compatible 16x2 character LCD over its 8-bit parallel interface.
- Holds a 32-entry character buffer, written one byte per clock from writeAddr/charCode. Addresses 0-15 are line 1; addresses 16-31 are line 2.
- Runs the LCD power-up/init sequence, then continuously refreshes both display lines from the buffer.
- Sits between user logic producing text and the board LCD pins.

Parameters:
- POWERUP_CYC, 1_000_000: idle cycles after power-on before the first command (20 ms at 50 MHz).
- EN_HIGH_CYC, 25: cycles lcdEnableOut is held high per transfer (500 ns).
- SETUP_CYC, 3: cycles RS/bus are stable before the enable rises.
- CMD_WAIT_CYC, 2_500: cycles after the enable falls for normal commands and data writes (50 us).
- CLEAR_WAIT_CYC, 100_000: cycles after the enable falls for the clear-display command (2 ms).

Ports:
- clk  in  1  system clock, rising edge (50 MHz nominal)
- resetN  in  1  asynchronous active-low reset
- lcdOnIn  in  1  1 = LCD powered and running; 0 = LCD off
- writeAddr  in  5  character buffer address (0-31)
- charCode  in  8  character code written to buffer[writeAddr]
- lcdBus  out  8  LCD data bus DB7..DB0
- lcdOnOut  out  1  LCD power/backlight enable
- lcdReadWriteSel  out  1  R/W pin; always 0 (write)
- lcdRsSelect  out  1  RS pin: 0 = command, 1 = data
- lcdEnableOut  out  1  E strobe
- errorLed  out  1  sticky error indicator

Behaviour:
- Reset values: all outputs 0. Buffer filled with 0x20 (space). FSM in OFF.
- Buffer write:
  - Every clock, buffer[writeAddr] <= charCode. There is no write enable.
  - Writes happen regardless of lcdOnIn.
  - If charCode < 0x20, store 0x20 instead and set errorLed.
  - errorLed stays set until reset.
- lcdOnOut is lcdOnIn registered, one cycle of latency.
- FSM states: OFF, PWR_WAIT, INIT (4-step command list), SET_LINE1, DATA_LINE1, SET_LINE2, DATA_LINE2.
  - OFF -> PWR_WAIT when lcdOnIn = 1.
  - PWR_WAIT waits POWERUP_CYC cycles, then -> INIT.
  - INIT issues 0x38 (function set: 8-bit, 2 lines), display-on (0x0C), 0x01 (clear), 0x06 (entry mode increment).
  - SET_LINE1 issues 0x80, then DATA_LINE1 writes buffer[0..15].
  - SET_LINE2 issues 0xC0, then DATA_LINE2 writes buffer[16..31].
  - After DATA_LINE2, loop back to SET_LINE1 forever.
- Transfer sub-sequence, applied to every command or data byte:
  - Drive lcdRsSelect and lcdBus.
  - Hold SETUP_CYC cycles.
  - Drive lcdEnableOut = 1 for EN_HIGH_CYC cycles, then 0.
  - Hold RS and bus for a further CMD_WAIT_CYC cycles; use CLEAR_WAIT_CYC after the 0x01 command.
- Data byte timing: a data byte is sampled from the buffer at the start of its transfer. A write to the same address in a later cycle shows up on the next refresh pass.
- lcdRsSelect: 0 during INIT and SET_LINE*, 1 during DATA_LINE*.
- lcdOnIn falling in any state:
  - Next cycle: FSM -> OFF, lcdEnableOut = 0, lcdBus = 0, lcdRsSelect = 0.
  - The transfer in progress is aborted. The buffer is kept.
  - Re-asserting lcdOnIn restarts from PWR_WAIT.
- Reset asserted mid-operation: immediate return to reset values.
- The step/character index wraps at 15 within each line.
- Wait counters are wide enough for the largest parameter, and saturate-free: load, then count down to 0.
- An illegal FSM encoding recovers to OFF.

Optional Feature:
- Macro LCD_CURSOR_BLINK_EN.
- Defined: the INIT display-on command is 0x0F (display, cursor and blink on).
- Undefined: the display-on command is 0x0C (display on, cursor off).
- No other behaviour changes.

Decomposition:
- Shared package lcd_pkg holds:
  - FSM state typedef.
  - Command constants: CMD_FUNC_SET = 0x38, CMD_DISP_ON = 0x0C, CMD_DISP_ON_BLINK = 0x0F, CMD_CLEAR = 0x01, CMD_ENTRY = 0x06, CMD_LINE1 = 0x80, CMD_LINE2 = 0xC0.
  - SPACE_CHAR = 0x20.
- One sub-module, lcd_xfer_timer: accepts start + rs + byte, generates the setup/enable/wait timing, and returns done.
- The top level holds the buffer, the sequencing FSM and errorLed.

Test Plan:
All tests use small parameters: POWERUP_CYC = 20, SETUP_CYC = 1, EN_HIGH_CYC = 2, CMD_WAIT_CYC = 4, CLEAR_WAIT_CYC = 8.
- Reset with lcdOnIn = 0 -> all outputs 0 and lcdEnableOut never pulses; resetN released with lcdOnIn = 1 -> lcdOnOut = 1 one cycle later and the first enable pulse occurs after 20 + 1 cycles.
- Init sequence -> four enable pulses with lcdRsSelect = 0 and lcdBus 0x38, 0x0C, 0x01, 0x06 in that order; the gap after 0x01 is 8 cycles, the others are 4.
- Write 0xF0 at every address 0-31 (counter stimulus) -> pulse with bus 0x80 (RS = 0), then 16 pulses bus 0xF0 (RS = 1), then 0xC0, then 16 pulses 0xF0; errorLed stays 0.
- Write charCode 0x05 to address 3 -> errorLed = 1 and stays 1; the 4th line-1 data byte is 0x20.
- Drop lcdOnIn mid-DATA_LINE1 -> next cycle lcdEnableOut = 0, lcdBus = 0; re-raise -> PWR_WAIT, then full init again.
- LCD_CURSOR_BLINK_EN defined -> the second init command is 0x0F.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command codes for the 16x2 character LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PWR_WAIT,
        ST_INIT,
        ST_SET_LINE1,
        ST_DATA_LINE1,
        ST_SET_LINE2,
        ST_DATA_LINE2
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ENABLE,
        PH_HOLD
    } xfer_phase_t;

    localparam logic [7:0] CMD_FUNC_SET      = 8'h38;
    localparam logic [7:0] CMD_DISP_ON       = 8'h0C;
    localparam logic [7:0] CMD_DISP_ON_BLINK = 8'h0F;
    localparam logic [7:0] CMD_CLEAR         = 8'h01;
    localparam logic [7:0] CMD_ENTRY         = 8'h06;
    localparam logic [7:0] CMD_LINE1         = 8'h80;
    localparam logic [7:0] CMD_LINE2         = 8'hC0;
    localparam logic [7:0] SPACE_CHAR        = 8'h20;

    // Power-up command list; the display-on code is chosen by the caller.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx, input logic [7:0] disp_cmd);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return disp_cmd;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_xfer_timer.sv
// One LCD bus transfer: setup, enable strobe, then post-strobe hold; done marks the last hold cycle.
module lcd_xfer_timer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC      = 3,
    parameter int EN_HIGH_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2_500,
    parameter int CLEAR_WAIT_CYC = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abort,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] data_in,
    input  logic       long_wait,
    output logic       rs,
    output logic [7:0] bus,
    output logic       en,
    output logic       done
);

    localparam int MAX_A   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC + 1);

    xfer_phase_t   phase;
    logic [CW-1:0] cnt;
    logic          long_q;

    // A new start may arrive in the final hold cycle, so back-to-back transfers have no idle gap.
    assign done = (phase == PH_HOLD) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= PH_IDLE;
            cnt    <= '0;
            rs     <= 1'b0;
            bus    <= '0;
            en     <= 1'b0;
            long_q <= 1'b0;
        end else if (abort) begin
            phase  <= PH_IDLE;
            cnt    <= '0;
            rs     <= 1'b0;
            bus    <= '0;
            en     <= 1'b0;
            long_q <= 1'b0;
        end else if (start) begin
            phase  <= PH_SETUP;
            cnt    <= CW'(SETUP_CYC - 1);
            rs     <= rs_in;
            bus    <= data_in;
            en     <= 1'b0;
            long_q <= long_wait;
        end else begin
            case (phase)
                PH_SETUP: begin
                    if (cnt == '0) begin
                        en    <= 1'b1;
                        phase <= PH_ENABLE;
                        cnt   <= CW'(EN_HIGH_CYC - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PH_ENABLE: begin
                    if (cnt == '0) begin
                        en    <= 1'b0;
                        phase <= PH_HOLD;
                        cnt   <= long_q ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PH_HOLD: begin
                    if (cnt == '0) begin
                        phase <= PH_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_controller.sv
// HD44780 16x2 controller: character buffer, init/refresh sequencer and sticky error flag.
// Define LCD_CURSOR_BLINK_EN to turn the cursor and blink on during init.
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 1_000_000,
    parameter int EN_HIGH_CYC    = 25,
    parameter int SETUP_CYC      = 3,
    parameter int CMD_WAIT_CYC   = 2_500,
    parameter int CLEAR_WAIT_CYC = 100_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       lcdOnIn,
    input  logic [4:0] writeAddr,
    input  logic [7:0] charCode,
    output logic [7:0] lcdBus,
    output logic       lcdOnOut,
    output logic       lcdReadWriteSel,
    output logic       lcdRsSelect,
    output logic       lcdEnableOut,
    output logic       errorLed
);

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_CMD = CMD_DISP_ON_BLINK;
`else
    localparam logic [7:0] DISP_CMD = CMD_DISP_ON;
`endif

    localparam int PW_W = $clog2(POWERUP_CYC + 1);

    logic [7:0]      buffer [32];
    lcd_state_t      state, nxt_state, tgt_state;
    logic [3:0]      step, nxt_step, tgt_step;
    logic [PW_W-1:0] wait_cnt;
    logic            start, done, xfer_state;
    logic            issue_rs, issue_long;
    logic [7:0]      issue_byte;

    assign lcdReadWriteSel = 1'b0;
    assign xfer_state      = state inside {ST_INIT, ST_SET_LINE1, ST_DATA_LINE1, ST_SET_LINE2, ST_DATA_LINE2};
    assign start           = lcdOnIn && (((state == ST_PWR_WAIT) && (wait_cnt == '0)) || (xfer_state && done));

    always_comb begin
        nxt_state = state;
        nxt_step  = step + 4'd1;
        case (state)
            ST_INIT:       if (step == 4'd3) begin nxt_state = ST_SET_LINE1; nxt_step = 4'd0; end
            ST_SET_LINE1:  begin nxt_state = ST_DATA_LINE1; nxt_step = 4'd0; end
            ST_DATA_LINE1: if (step == 4'd15) nxt_state = ST_SET_LINE2;
            ST_SET_LINE2:  begin nxt_state = ST_DATA_LINE2; nxt_step = 4'd0; end
            ST_DATA_LINE2: if (step == 4'd15) nxt_state = ST_SET_LINE1;
            default:       ;
        endcase
    end

    // The byte handed to the timer belongs to the state/step being entered; data bytes are read here.
    always_comb begin
        tgt_state  = (state == ST_PWR_WAIT) ? ST_INIT : nxt_state;
        tgt_step   = (state == ST_PWR_WAIT) ? 4'd0 : nxt_step;
        issue_byte = '0;
        issue_rs   = 1'b0;
        issue_long = 1'b0;
        case (tgt_state)
            ST_INIT: begin
                issue_byte = init_cmd(tgt_step[1:0], DISP_CMD);
                issue_long = (tgt_step[1:0] == 2'd2);
            end
            ST_SET_LINE1:  issue_byte = CMD_LINE1;
            ST_SET_LINE2:  issue_byte = CMD_LINE2;
            ST_DATA_LINE1: begin issue_byte = buffer[{1'b0, tgt_step}]; issue_rs = 1'b1; end
            ST_DATA_LINE2: begin issue_byte = buffer[{1'b1, tgt_step}]; issue_rs = 1'b1; end
            default:       ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 32; i++) buffer[i] <= SPACE_CHAR;
            errorLed <= 1'b0;
            lcdOnOut <= 1'b0;
        end else begin
            lcdOnOut <= lcdOnIn;
            if (charCode < SPACE_CHAR) begin
                buffer[writeAddr] <= SPACE_CHAR;
                errorLed          <= 1'b1;
            end else begin
                buffer[writeAddr] <= charCode;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= ST_OFF;
            step     <= '0;
            wait_cnt <= '0;
        end else if (!lcdOnIn) begin
            state    <= ST_OFF;
            step     <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state    <= ST_PWR_WAIT;
                    wait_cnt <= PW_W'(POWERUP_CYC - 1);
                end
                ST_PWR_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_INIT;
                        step  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - PW_W'(1);
                    end
                end
                ST_INIT, ST_SET_LINE1, ST_DATA_LINE1, ST_SET_LINE2, ST_DATA_LINE2: begin
                    if (done) begin
                        state <= nxt_state;
                        step  <= nxt_step;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    step  <= '0;
                end
            endcase
        end
    end

    lcd_xfer_timer #(
        .SETUP_CYC      (SETUP_CYC),
        .EN_HIGH_CYC    (EN_HIGH_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) u_xfer (
        .clk       (clk),
        .rst_n     (resetN),
        .abort     (!lcdOnIn),
        .start     (start),
        .rs_in     (issue_rs),
        .data_in   (issue_byte),
        .long_wait (issue_long),
        .rs        (lcdRsSelect),
        .bus       (lcdBus),
        .en        (lcdEnableOut),
        .done      (done)
    );

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboard bench for lcd_controller: expected LCD transfers are queued by the stimulus and popped on each enable rise.
module tb_lcd_controller;

    localparam int POWERUP_CYC    = 20;
    localparam int SETUP_CYC      = 1;
    localparam int EN_HIGH_CYC    = 2;
    localparam int CMD_WAIT_CYC   = 4;
    localparam int CLEAR_WAIT_CYC = 8;

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] EXP_DISP = 8'h0F;
`else
    localparam logic [7:0] EXP_DISP = 8'h0C;
`endif

    logic       clk;
    logic       resetN;
    logic       lcdOnIn;
    logic [4:0] writeAddr;
    logic [7:0] charCode;
    logic [7:0] lcdBus;
    logic       lcdOnOut;
    logic       lcdReadWriteSel;
    logic       lcdRsSelect;
    logic       lcdEnableOut;
    logic       errorLed;

    logic [8:0] sb [$];
    bit         sb_armed;
    int         n_checks;
    int         n_fail;
    int         rise_count;
    int         first_rise;
    int         base;

    logic       en_prev, have_prev, prev_long;
    int         high_len, low_len, cyc_on;
    logic [7:0] rise_bus;
    logic       rise_rs;
    logic [8:0] exp_x;

    lcd_controller #(
        .POWERUP_CYC    (POWERUP_CYC),
        .EN_HIGH_CYC    (EN_HIGH_CYC),
        .SETUP_CYC      (SETUP_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .lcdOnIn         (lcdOnIn),
        .writeAddr       (writeAddr),
        .charCode        (charCode),
        .lcdBus          (lcdBus),
        .lcdOnOut        (lcdOnOut),
        .lcdReadWriteSel (lcdReadWriteSel),
        .lcdRsSelect     (lcdRsSelect),
        .lcdEnableOut    (lcdEnableOut),
        .errorLed        (errorLed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] addr, input logic [7:0] code);
        writeAddr = addr;
        charCode  = code;
        @(negedge clk);
    endtask

    task automatic expectXfer(input logic rs, input logic [7:0] b);
        sb.push_back({rs, b});
    endtask

    task automatic expectInit();
        expectXfer(1'b0, 8'h38);
        expectXfer(1'b0, EXP_DISP);
        expectXfer(1'b0, 8'h01);
        expectXfer(1'b0, 8'h06);
    endtask

    // One refresh pass with 0xF0 everywhere except line-1 position alt_idx.
    task automatic expectPass(input int alt_idx, input logic [7:0] alt_byte);
        expectXfer(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) expectXfer(1'b1, (i == alt_idx) ? alt_byte : 8'hF0);
        expectXfer(1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) expectXfer(1'b1, 8'hF0);
    endtask

    task automatic waitEmpty(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checkOutput(tag, 32'(sb.size()), 32'd0);
    endtask

    // Enable-low span between pulses is the previous hold plus the next byte's setup.
    always @(negedge clk) begin
        if (!resetN || !lcdOnOut) begin
            en_prev   = 1'b0;
            have_prev = 1'b0;
            high_len  = 0;
            low_len   = 0;
            cyc_on    = 0;
        end else begin
            cyc_on++;
            if (lcdEnableOut && !en_prev) begin
                rise_count++;
                if (first_rise < 0) first_rise = cyc_on - 1;
                if (have_prev)
                    checkOutput("enable_gap", 32'(low_len),
                                32'((prev_long ? CLEAR_WAIT_CYC : CMD_WAIT_CYC) + SETUP_CYC));
                if (sb_armed) begin
                    n_checks++;
                    assert (sb.size() != 0) else begin
                        n_fail++;
                        $error("[TB] FAIL unexpected_pulse: observed rs=%0b bus=0x%0h, expected no pulse",
                               lcdRsSelect, lcdBus);
                    end
                    if (sb.size() != 0) begin
                        exp_x = sb.pop_front();
                        checkOutput("xfer_rs_bus", 32'({lcdRsSelect, lcdBus}), 32'(exp_x));
                    end
                end
                high_len = 1;
                rise_bus = lcdBus;
                rise_rs  = lcdRsSelect;
            end else if (lcdEnableOut) begin
                high_len++;
            end else if (en_prev) begin
                checkOutput("enable_width", 32'(high_len), 32'(EN_HIGH_CYC));
                checkOutput("bus_stable", 32'({lcdRsSelect, lcdBus}), 32'({rise_rs, rise_bus}));
                prev_long = (rise_bus == 8'h01) && !rise_rs;
                have_prev = 1'b1;
                low_len   = 1;
            end else begin
                low_len++;
            end
            en_prev = lcdEnableOut;
        end
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rise_count = 0;
        first_rise = -1;
        sb_armed   = 1'b0;
        resetN     = 1'b0;
        lcdOnIn    = 1'b0;
        writeAddr  = 5'd0;
        charCode   = 8'h20;
        repeat (3) @(negedge clk);
        checkOutput("rst_bus", 32'(lcdBus), 32'd0);
        checkOutput("rst_on", 32'(lcdOnOut), 32'd0);
        checkOutput("rst_rw", 32'(lcdReadWriteSel), 32'd0);
        checkOutput("rst_rs", 32'(lcdRsSelect), 32'd0);
        checkOutput("rst_en", 32'(lcdEnableOut), 32'd0);
        checkOutput("rst_err", 32'(errorLed), 32'd0);

        resetN = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("off_no_pulse", 32'(rise_count), 32'd0);
        checkOutput("off_lcdOnOut", 32'(lcdOnOut), 32'd0);
        checkOutput("off_rw", 32'(lcdReadWriteSel), 32'd0);

        resetN  = 1'b0;
        lcdOnIn = 1'b1;
        @(negedge clk);
        checkOutput("rst_held_on", 32'(lcdOnOut), 32'd0);
        sb.delete();
        expectInit();
        expectPass(-1, 8'h00);
        first_rise = -1;
        sb_armed   = 1'b1;
        resetN     = 1'b1;
        #1;
        checkOutput("on_pre_edge", 32'(lcdOnOut), 32'd0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(5'(i), 8'hF0);
            if (i == 0) checkOutput("on_latency", 32'(lcdOnOut), 32'd1);
        end
        waitEmpty("pass1_done");
        checkOutput("first_rise", 32'(first_rise), 32'(POWERUP_CYC + SETUP_CYC));
        checkOutput("err_clean", 32'(errorLed), 32'd0);

        expectPass(3, 8'h20);
        applyStimulus(5'd3, 8'h05);
        checkOutput("err_set", 32'(errorLed), 32'd1);
        applyStimulus(5'd31, 8'hF0);
        waitEmpty("pass2_done");
        checkOutput("err_sticky", 32'(errorLed), 32'd1);

        sb_armed = 1'b0;
        base     = rise_count;
        applyStimulus(5'd3, 8'h41);
        applyStimulus(5'd31, 8'hF0);
        checkOutput("err_sticky_valid", 32'(errorLed), 32'd1);
        for (int t = 0; t < 500 && rise_count < base + 4; t++) @(negedge clk);
        checkOutput("pre_drop_en", 32'(lcdEnableOut), 32'd1);
        lcdOnIn = 1'b0;
        @(negedge clk);
        checkOutput("drop_en", 32'(lcdEnableOut), 32'd0);
        checkOutput("drop_bus", 32'(lcdBus), 32'd0);
        checkOutput("drop_rs", 32'(lcdRsSelect), 32'd0);
        checkOutput("drop_on", 32'(lcdOnOut), 32'd0);
        base = rise_count;
        repeat (15) @(negedge clk);
        checkOutput("off_quiet", 32'(rise_count), 32'(base));

        sb.delete();
        expectInit();
        expectPass(3, 8'h41);
        first_rise = -1;
        sb_armed   = 1'b1;
        lcdOnIn    = 1'b1;
        waitEmpty("reinit_done");
        checkOutput("reinit_first_rise", 32'(first_rise), 32'(POWERUP_CYC + SETUP_CYC));
        sb_armed = 1'b0;

        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("async_rst_en", 32'(lcdEnableOut), 32'd0);
        checkOutput("async_rst_bus", 32'(lcdBus), 32'd0);
        checkOutput("async_rst_rs", 32'(lcdRsSelect), 32'd0);
        checkOutput("async_rst_on", 32'(lcdOnOut), 32'd0);
        checkOutput("async_rst_err", 32'(errorLed), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
